stego_lsb_extract: RTL
======================

Name: stego_lsb_extract

Overview:
- Downstream consumer of the stego image memory stage: accepts stego-image pixel bytes one per handshake, strips each pixel's LSB and reassembles the hidden message.
- Payload format: 16-bit little-endian length header, then LEN message bytes, then an optional checksum byte.
- Emits message bytes on a valid/ready stream to the message sink / UART stage.

Parameters:
- MAX_LEN, 200, largest legal message length in bytes; larger headers are rejected.
- LEN_W, 16, header length field width; fixed at 2 header bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; arms extraction from IDLE or DONE.
- pix_valid  in  1  pixel byte present.
- pix_data  in  8  stego pixel byte; only bit 0 is used.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- msg_valid  out  1  msg_data holds a message byte.
- msg_data  out  8  extracted message byte.
- msg_ready  in  1  sink accepts the byte when msg_valid && msg_ready.
- msg_len  out  LEN_W  decoded header length; valid from header completion until the next start.
- busy  out  1  high in HDR and PAYLOAD.
- done  out  1  high in DONE; cleared by start or rst.
- err  out  1  length error, or checksum error when the option is enabled; cleared by start or rst.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - Outputs: pix_ready=0, msg_valid=0, msg_data=0, msg_len=0, busy=0, done=0, err=0.
  - Internal: bit_cnt=0, byte_cnt=0, shift register=0.
  - rst asserted mid-message aborts immediately; partial bytes are discarded.
- Bit packing:
  - Pixels are consumed in order; the k-th accepted pixel of a byte (k=0..7) supplies bit k (LSB-first).
  - A byte completes on the 8th accepted pixel; bit_cnt wraps 7->0.
- States:
  - IDLE: pix_ready=0. start -> HDR; all counters and err are cleared.
  - HDR: pix_ready=1. Byte 0 -> msg_len[7:0]; byte 1 -> msg_len[15:8]. On byte 1 completion, the next state is:
    - DONE with err=1 when the length > MAX_LEN;
    - DONE when the length = 0 (or CHK when checksum is enabled);
    - otherwise PAYLOAD.
  - PAYLOAD: each completed byte loads msg_data and sets msg_valid=1 in the cycle after the 8th pixel handshake (latency 1 clk). byte_cnt increments on load. After byte msg_len-1 is loaded -> DONE (or CHK).
  - DONE: done=1, pix_ready=0. start -> HDR (new extraction); a pixel stream offered in DONE is ignored.
- Backpressure:
  - pix_ready = (HDR or PAYLOAD) && !(msg_valid && !msg_ready).
  - A single output register; no byte is ever dropped or duplicated.
  - msg_valid, once set, holds with msg_data stable until msg_ready.
  - When a byte completes in the same cycle the previous byte handshakes, the new byte loads with no bubble.
- start while busy is ignored.
- Header bytes never appear on msg_*.
- The final msg byte may still be pending in DONE. done asserts on entry to DONE regardless of drain; msg_valid still obeys the handshake.

Optional Feature:
- Macro: STEGO_LSB_CHECKSUM_EN.
- Defined:
  - Adds a CHK state after PAYLOAD (or after a zero-length header).
  - Consumes one more 8-pixel byte and compares it with the XOR of all payload bytes (XOR of none = 0x00).
  - A mismatch sets err=1 on entry to DONE.
  - The checksum byte is never emitted on msg_*.
- Undefined: no CHK state; err reflects only the length error.

Decomposition:
- Shared package stego_pkg: state encoding constants (IDLE, HDR, PAYLOAD, CHK, DONE), LEN_W, header byte count (2), bits per byte (8).
- One natural sub-module, stego_lsb_packer: 8-bit LSB-first shift register with bit counter and byte_done strobe, gated by the pixel handshake.
- The state machine, counters and output register stay in the top module.

Test Plan:
- Header pixels encode len=3, payload "ABC"; msg_ready=1 -> msg_data 0x41, 0x42, 0x43; each appears 1 clk after its 8th pixel; done=1; err=0; msg_len=3.
- Same stream with msg_ready toggled 1-in-3 and random pix_valid gaps -> bytes identical and in order; pix_ready=0 while msg_valid && !msg_ready.
- Header len=0 -> no msg_valid pulse; DONE directly after 16 pixels.
- Header len=201 (MAX_LEN=200) -> err=1, done=1, zero bytes emitted.
- rst pulsed after 12 payload pixels -> all outputs at reset values next cycle; a following start and full stream decode correctly.
- With STEGO_LSB_CHECKSUM_EN: payload 0x12, 0x34 with checksum 0x26 -> err=0; checksum 0x27 -> err=1.

Source files
------------

// File: rtl/stego_lsb_extract_pkg.sv
// -----------------------------------------------------------------------------
// stego_pkg
// Shared definitions for the LSB steganography extractor: state encoding,
// header geometry and byte packing constants.
// -----------------------------------------------------------------------------
package stego_pkg;

    localparam int HDR_LEN_W     = 16;  // width of the little-endian length header
    localparam int HDR_BYTES     = 2;   // header is always two bytes
    localparam int BITS_PER_BYTE = 8;   // pixels per reassembled byte
    localparam int CNT_W         = $clog2(BITS_PER_BYTE);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CHK,
        DONE
    } state_t;

endpackage

// File: rtl/stego_lsb_extract_if.sv
// -----------------------------------------------------------------------------
// stego_lsb_extract_if
// Pixel input stream and message output stream of the extractor.
//   pix_valid/pix_data/pix_ready : stego pixel bytes in (bit 0 carries payload)
//   msg_valid/msg_data/msg_ready : recovered message bytes out
// master = the environment (pixel source + message sink), slave = extractor.
// -----------------------------------------------------------------------------
interface stego_lsb_extract_if;

    logic                                 pix_valid;
    logic [stego_pkg::BITS_PER_BYTE-1:0]  pix_data;
    logic                                 pix_ready;
    logic                                 msg_valid;
    logic [stego_pkg::BITS_PER_BYTE-1:0]  msg_data;
    logic                                 msg_ready;

    modport master (
        output pix_valid, pix_data, msg_ready,
        input  pix_ready, msg_valid, msg_data
    );

    modport slave (
        input  pix_valid, pix_data, msg_ready,
        output pix_ready, msg_valid, msg_data
    );

endinterface

// File: rtl/stego_lsb_extract_packer.sv
// -----------------------------------------------------------------------------
// stego_lsb_packer
// LSB-first byte assembler. Every accepted pixel bit is placed at position
// bit_cnt; the 8th accepted bit raises byte_done for that same cycle with the
// complete byte on byte_data.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart packing (discard any partial byte)
//   bit_vld    : pixel handshake occurred this cycle
//   bit_in     : LSB of the accepted pixel
//   byte_done  : combinational strobe, byte completes on this handshake
//   byte_data  : assembled byte (meaningful when byte_done)
// -----------------------------------------------------------------------------
module stego_lsb_packer
    import stego_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     bit_vld,
    input  logic                     bit_in,
    output logic                     byte_done,
    output logic [BITS_PER_BYTE-1:0] byte_data
);

    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_BYTE-1:0] shreg_q, shreg_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        // Current partial byte with the incoming bit merged in, so the full
        // byte is available on the same cycle as the final handshake.
        byte_data            = shreg_q;
        byte_data[bit_cnt_q] = bit_in;
        if (clr) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (bit_vld) begin
            bit_cnt_d = bit_cnt_q + 1'b1;  // wraps 7 -> 0
            byte_done = (bit_cnt_q == CNT_W'(BITS_PER_BYTE - 1));
            shreg_d   = byte_done ? '0 : byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

endmodule

// File: rtl/stego_lsb_extract.sv
// -----------------------------------------------------------------------------
// stego_lsb_extract
// Recovers a hidden message from the LSBs of stego pixel bytes. Stream format:
// 16-bit little-endian length, LEN message bytes, optional checksum byte.
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse, arms a new extraction from IDLE or DONE
//   bus       : slave side of stego_lsb_extract_if (pixels in, message out)
//   msg_len   : decoded header length, held until the next start
//   busy      : extraction in progress
//   done      : extraction finished (final byte may still be draining)
//   err       : length too large, or checksum mismatch
// Build option: define STEGO_LSB_CHECKSUM_EN to add the trailing checksum
// byte (XOR of all payload bytes) and its CHK state.
// -----------------------------------------------------------------------------
module stego_lsb_extract
    import stego_pkg::*;
#(
    parameter int MAX_LEN = 200,
    parameter int LEN_W   = HDR_LEN_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    stego_lsb_extract_if.slave    bus,
    output logic [LEN_W-1:0]      msg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

`ifdef STEGO_LSB_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CHK;
`else
    localparam state_t AFTER_PAYLOAD = DONE;
`endif

    state_t                   state_q, state_d;
    logic [LEN_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [BITS_PER_BYTE-1:0] hdr_lo_q, hdr_lo_d;
    logic                     err_q, err_d;
    logic                     msg_valid_q, msg_valid_d;
    logic [BITS_PER_BYTE-1:0] msg_data_q, msg_data_d;
`ifdef STEGO_LSB_CHECKSUM_EN
    logic [BITS_PER_BYTE-1:0] xor_q, xor_d;
`endif

    logic                     consume_st;
    logic                     pix_hs;
    logic                     pack_clr;
    logic                     byte_done;
    logic [BITS_PER_BYTE-1:0] byte_data;
    logic [LEN_W-1:0]         hdr_len;
    logic [BITS_PER_BYTE-2:0] unused_pix_bits;

    assign unused_pix_bits = bus.pix_data[BITS_PER_BYTE-1:1];

    // Pixels are only taken while the output register can absorb a new byte.
    assign consume_st    = (state_q == HDR) || (state_q == PAYLOAD) || (state_q == CHK);
    assign bus.pix_ready = consume_st && !(msg_valid_q && !bus.msg_ready);
    assign pix_hs        = bus.pix_valid && bus.pix_ready;

    stego_lsb_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pack_clr),
        .bit_vld   (pix_hs),
        .bit_in    (bus.pix_data[0]),
        .byte_done (byte_done),
        .byte_data (byte_data)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        len_d       = len_q;
        hdr_lo_d    = hdr_lo_q;
        err_d       = err_q;
        msg_valid_d = msg_valid_q;
        msg_data_d  = msg_data_q;
        pack_clr    = 1'b0;
        hdr_len     = {byte_data, hdr_lo_q};
`ifdef STEGO_LSB_CHECKSUM_EN
        xor_d       = xor_q;
`endif

        if (msg_valid_q && bus.msg_ready) begin
            msg_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = HDR;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    hdr_lo_d   = '0;
                    err_d      = 1'b0;
                    pack_clr   = 1'b1;
`ifdef STEGO_LSB_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            HDR: begin
                if (byte_done) begin
                    if (byte_cnt_q == '0) begin
                        hdr_lo_d   = byte_data;
                        byte_cnt_d = LEN_W'(1);
                    end else begin
                        len_d      = hdr_len;
                        byte_cnt_d = '0;
                        if (hdr_len > LEN_W'(MAX_LEN)) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else if (hdr_len == '0) begin
                            state_d = AFTER_PAYLOAD;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                // pix_ready guarantees the output register is free or
                // handshaking now, so loading here never overwrites a byte.
                if (byte_done) begin
                    msg_data_d  = byte_data;
                    msg_valid_d = 1'b1;
                    byte_cnt_d  = byte_cnt_q + LEN_W'(1);
`ifdef STEGO_LSB_CHECKSUM_EN
                    xor_d       = xor_q ^ byte_data;
`endif
                    if (byte_cnt_d == len_q) begin
                        state_d = AFTER_PAYLOAD;
                    end
                end
            end
`ifdef STEGO_LSB_CHECKSUM_EN
            CHK: begin
                if (byte_done) begin
                    if (byte_data != xor_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            len_q       <= '0;
            hdr_lo_q    <= '0;
            err_q       <= 1'b0;
            msg_valid_q <= 1'b0;
            msg_data_q  <= '0;
`ifdef STEGO_LSB_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            hdr_lo_q    <= hdr_lo_d;
            err_q       <= err_d;
            msg_valid_q <= msg_valid_d;
            msg_data_q  <= msg_data_d;
`ifdef STEGO_LSB_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign bus.msg_valid = msg_valid_q;
    assign bus.msg_data  = msg_data_q;
    assign msg_len       = len_q;
    assign busy          = consume_st;
    assign done          = (state_q == DONE);
    assign err           = err_q;

endmodule
